// File: rtl/rsa_sched.sv
// rsa_sched: round-robin scheduler sharing one RSA modexp engine between two requesters
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request and one-hot accept strobe
//   req0_*, req1_*        requester operands (exponent, modulus, message)
//   rsp_valid/rsp_err     one-cycle response strobe to the owner, error = timeout abort
//   rsp_c                 result, held until the next response
//   eng_*                 engine operands, start pulse, reset, result and done
module rsa_sched #(
  parameter int WIDTH = 256,
  parameter int TIMEOUT = 1048576
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_e,
  input  logic [WIDTH-1:0] req0_n,
  input  logic [WIDTH-1:0] req0_m,
  input  logic [WIDTH-1:0] req1_e,
  input  logic [WIDTH-1:0] req1_n,
  input  logic [WIDTH-1:0] req1_m,
  output logic [1:0]       rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_c,
  output logic [WIDTH-1:0] eng_e,
  output logic [WIDTH-1:0] eng_n,
  output logic [WIDTH-1:0] eng_m,
  output logic             eng_ready,
  output logic             eng_reset,
  input  logic [WIDTH-1:0] eng_c,
  input  logic             eng_valid
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic owner, last, abort_q, gnt, timeout, accept, finish;
  // on a tie the requester that was not served last wins
  assign gnt = (req_valid == 2'b11) ? ~last : req_valid[1];
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign accept = state == IDLE && |req_valid;
  assign finish = state == BUSY && (eng_valid || timeout);
  assign eng_reset = reset | abort_q;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (|req_valid ? LOAD : IDLE) :
              state == LOAD ? BUSY :
              state == BUSY ? (finish ? DONE : BUSY) : IDLE;
    req_ready = (accept && !reset) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    eng_ready = state == LOAD;
    rsp_valid = state == DONE ? (owner ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_e <= '0;
      eng_n <= '0;
      eng_m <= '0;
      owner <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      abort_q <= 1'b0;
      rsp_c <= '0;
      rsp_err <= 1'b0;
    end else begin
      // valid beats timeout when both land in the same cycle
      abort_q <= state == BUSY && !eng_valid && timeout;
      cnt <= state == BUSY ? cnt + 1'b1 : '0;
      if (accept) begin
        owner <= gnt;
        eng_e <= gnt ? req1_e : req0_e;
        eng_n <= gnt ? req1_n : req0_n;
        eng_m <= gnt ? req1_m : req0_m;
      end
      if (finish) begin
        rsp_c <= eng_valid ? eng_c : '0;
        rsp_err <= !eng_valid;
        last <= owner;
      end
    end
  end
endmodule

// File: tb/tb_rsa_sched.sv
// tb_rsa_sched: directed table-driven bench for rsa_sched with a bench-played mock engine
module tb_rsa_sched;
  localparam int W = 256;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready, rsp_valid;
  logic [W-1:0] req0_e = '0, req0_n = '0, req0_m = '0;
  logic [W-1:0] req1_e = '0, req1_n = '0, req1_m = '0;
  logic rsp_err, eng_ready, eng_reset;
  logic [W-1:0] rsp_c, eng_e, eng_n, eng_m;
  logic [W-1:0] eng_c = '0;
  logic eng_valid = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_c = '0;

  rsa_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_e(req0_e), .req0_n(req0_n), .req0_m(req0_m),
    .req1_e(req1_e), .req1_n(req1_n), .req1_m(req1_m),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_c(rsp_c),
    .eng_e(eng_e), .eng_n(eng_n), .eng_m(eng_m),
    .eng_ready(eng_ready), .eng_reset(eng_reset),
    .eng_c(eng_c), .eng_valid(eng_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rv;
    logic [1:0] xr;
    logic [W-1:0] e, n, m, cv;
    int lat;
    logic xe;
    logic [W-1:0] xc;
  } job_t;

  job_t tab[5];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_c"}, rsp_c, 0);
    chk({tag, "_eng_e"}, eng_e, 0);
    chk({tag, "_eng_n"}, eng_n, 0);
    chk({tag, "_eng_m"}, eng_m, 0);
    chk({tag, "_eng_ready"}, eng_ready, 0);
    chk({tag, "_eng_reset"}, eng_reset, 1);
  endtask

  // lat = BUSY cycle (1-based) in which the mock raises eng_valid; 0 = never
  task automatic run_job(input logic [1:0] rv, input logic [1:0] xr, input logic [W-1:0] e,
                         input logic [W-1:0] n, input logic [W-1:0] m, input logic [W-1:0] cv,
                         input int lat, input logic xe, input logic [W-1:0] xc, input bit hold);
    @(negedge clk);
    req_valid = rv;
    {req0_e, req0_n, req0_m} = xr[1] ? {~e, ~n, ~m} : {e, n, m};
    {req1_e, req1_n, req1_m} = xr[1] ? {e, n, m} : {~e, ~n, ~m};
    #1;
    chk("grant", req_ready, xr);
    chk("grant_onehot", W'($countones(req_ready) <= 1), 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_eng_reset", eng_reset, 0);
    chk("rsp_c_hold", rsp_c, prev_c);
    @(negedge clk);
    req_valid = hold ? rv : 2'b00;
    {req0_e, req0_n, req0_m} = {e + 1, n + 1, m + 1};
    {req1_e, req1_n, req1_m} = {e + 2, n + 2, m + 2};
    eng_valid = 1'b1;
    eng_c = ~cv;
    #1;
    chk("load_eng_ready", eng_ready, 1);
    chk("load_eng_e", eng_e, e);
    chk("load_eng_n", eng_n, n);
    chk("load_eng_m", eng_m, m);
    chk("load_req_ready", req_ready, 0);
    for (int i = 1; i <= (lat != 0 ? lat : TO); i++) begin
      @(negedge clk);
      eng_valid = i == lat;
      eng_c = cv;
      #1;
      chk("busy_eng_ready", eng_ready, 0);
      chk("busy_rsp_valid", rsp_valid, 0);
      chk("busy_eng_reset", eng_reset, 0);
      chk("busy_eng_e", eng_e, e);
      chk("busy_eng_m", eng_m, m);
    end
    @(negedge clk);
    eng_valid = 1'b0;
    eng_c = ~cv;
    #1;
    chk("done_rsp_valid", rsp_valid, xr);
    chk("done_rsp_err", rsp_err, xe);
    chk("done_rsp_c", rsp_c, xc);
    chk("done_eng_reset", eng_reset, xe);
    chk("done_eng_n", eng_n, n);
    chk("done_req_ready", req_ready, 0);
    prev_c = xc;
  endtask

  initial begin
    tab[0] = '{2'b01, 2'b01, 256'h10001,
               256'h807DB78B_1C4F2A90_5E6D7C8B_9A0F1E2D_3C4B5A69_78879695_A4B3C2D1_E0F13421,
               256'h0002FFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF0030_31300D06_09608648_01652E2E,
               256'h1234_5678_9ABC_DEF0, 10, 1'b0, 256'h1234_5678_9ABC_DEF0};
    tab[1] = '{2'b10, 2'b10, 256'h3, 256'hC5, 256'h41, 256'h8E, 3, 1'b0, 256'h8E};
    tab[2] = '{2'b01, 2'b01, 256'h11, 256'hDEADBEEF, 256'h7, 256'hFFFF, 0, 1'b1, 256'h0};
    tab[3] = '{2'b10, 2'b10, 256'h5, 256'hF00D, 256'h99, 256'hABCD, 16, 1'b0, 256'hABCD};
    tab[4] = '{2'b01, 2'b01, 256'h7, 256'hBB, 256'h2, 256'h77, 1, 1'b0, 256'h77};
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk_zero_outputs("por");
    req_valid = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("por_release_eng_reset", eng_reset, 0);
    for (int k = 0; k < 5; k++)
      run_job(tab[k].rv, tab[k].xr, tab[k].e, tab[k].n, tab[k].m, tab[k].cv,
              tab[k].lat, tab[k].xe, tab[k].xc, 1'b0);
    // reset mid-BUSY drops the job silently
    @(negedge clk);
    req_valid = 2'b10;
    {req1_e, req1_n, req1_m} = {256'h21, 256'h22, 256'h23};
    #1;
    chk("rst_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req_valid = 2'b11;
    eng_valid = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    reset = 1'b0;
    req_valid = 2'b00;
    eng_valid = 1'b0;
    prev_c = '0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_eng_reset", eng_reset, 0);
      chk("post_rst_eng_ready", eng_ready, 0);
    end
    // ties alternate starting with requester 0 after reset
    for (int k = 0; k < 6; k++)
      run_job(2'b11, k[0] ? 2'b10 : 2'b01, W'(k + 40), W'(k + 50), W'(k + 60),
              W'(k + 100), 2, 1'b0, W'(k + 100), 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("end_rsp_valid", rsp_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
